dense_pass_scheduler: RTL and testbench
=======================================

# dense_pass_scheduler

Controller that time-multiplexes a bank of `PAR` parallel dense neurons across `OUT_NEUR` output neurons. It takes one input vector per upstream handshake and issues `NPASS = ceil(OUT_NEUR/PAR)` start/done passes to the neuron bank, selecting the weight/bias slice by pass index. It collects each pass's lane results into an output buffer and presents the full output vector downstream with a valid/ready handshake. It sits between the pooling/flatten stage and the dense datapath and replaces a fully parallel instantiation of all output neurons.

## Interface
Parameters:
- `DATA_W`, 16: fixed-point word width.
- `OUT_NEUR`, 32: total output neurons; requires `PAR <= OUT_NEUR`.
- `PAR`, 8: neurons computed per pass (datapath lanes).
- `DONE_TIMEOUT`, 1023: maximum WAIT cycles per pass before error; must be ≥ 1.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream input vector is present.
- `in_ready` out 1: equals 1 exactly when the state is IDLE.
- `dp_start` out 1: single-cycle start pulse to the neuron bank.
- `dp_pass` out `$clog2(NPASS)` (minimum 1): current pass index; selects the weight/bias rows `dp_pass*PAR` to `dp_pass*PAR+PAR-1`.
- `dp_done` in 1: single-cycle done pulse from the neuron bank.
- `dp_out` in `PAR*DATA_W`: lane results, lane 0 in the LSBs, signed.
- `out_valid` out 1: output vector available.
- `out_ready` in 1: downstream accepts.
- `out_vec` out `OUT_NEUR*DATA_W`: neuron 0 in the LSBs, signed.
- `busy` out 1: high in START, WAIT and OUT.
- `err` out 1: sticky timeout flag.

## Operation
States:
- **IDLE**: `in_ready`=1. On `in_valid` → START with `dp_pass`=0.
- **START**: `dp_start`=1 for exactly this cycle; clear the timeout counter → WAIT.
- **WAIT**:
  - On `dp_done`: capture lanes into buffer slots `dp_pass*PAR+i`. Write only slots with index below `OUT_NEUR`; discard the excess lanes on the last pass.
  - If `dp_pass == NPASS-1` → OUT; otherwise increment `dp_pass` → START.
- **OUT**: `out_valid`=1 and `out_vec` is stable. On `out_ready` → IDLE with `dp_pass`=0.
- **ERR**: `err`=1. All handshakes are deasserted. Only `rst` exits this state.

Rules:
- The upstream holds the input vector stable while `busy`=1. The datapath reads it directly; this block does not store it.
- `dp_done` is sampled only in WAIT. It is ignored in IDLE, START, OUT and ERR.
- Timeout: the counter increments on each WAIT cycle that has no `dp_done`.
  - A `dp_done` arriving in WAIT cycles 1 through `DONE_TIMEOUT` is accepted. A done on the final allowed cycle wins.
  - If no done has arrived by the end of WAIT cycle `DONE_TIMEOUT` → ERR.
- Capture is a plain copy of the lane values, with no arithmetic (unless the ReLU macro below is defined). Buffer slots not written in the current frame keep their previous values.
- The output buffer is retained after the OUT handshake until the next frame overwrites it.

## Timing
- Reset values:
  - `in_ready`=1 (state IDLE).
  - `dp_start`=0, `dp_pass`=0, `out_valid`=0, `out_vec`=0, `busy`=0, `err`=0.
  - Timeout counter is 0.
- Reset mid-operation: the next cycle is IDLE with all reset values; a partial frame is discarded. The datapath shares `rst` (it must be reset alongside this block).
- Accept on cycle 0 (IDLE with `in_valid`=1). `dp_start` is high on cycle 1.
- `dp_done` must arrive k ≥ 1 cycles after `dp_start`. Each pass takes k+1 cycles.
- `out_valid` first rises on cycle `NPASS*(k+1)+1`.
- Handshake `out_valid & out_ready` on cycle t: `out_valid`=0 and `in_ready`=1 on cycle t+1. A new accept is possible on cycle t+1.
- `dp_pass` is stable from START through WAIT of each pass.

## Configuration
- `DENSE_SEQ_RELU_EN` defined: each captured lane value is passed through ReLU (negative values → 0) before it is written to the buffer.
- `DENSE_SEQ_RELU_EN` undefined: raw signed values are stored.

## Test plan
- PAR=8, OUT_NEUR=32, done at k=3, lanes = `pass*8+i` → 4 passes. `dp_pass` steps 0,1,2,3. `out_valid` rises on cycle 17. `out_vec[j]`=j for j=0..31.
- PAR=12, OUT_NEUR=32 → 3 passes. The last pass writes only slots 24..31; lanes 8..11 are discarded. Slots 0..23 are unchanged by the last pass.
- Hold `out_ready`=0 for 10 cycles → `out_valid` and `out_vec` are stable throughout and no `dp_start` pulses. Then `out_ready`=1 → `in_ready`=1 on the next cycle. A back-to-back frame is accepted on that cycle.
- DONE_TIMEOUT=4, `dp_done` never asserted → ERR after 4 WAIT cycles; `err`=1 and stays high, `in_ready`=0. Then `rst` → all reset values.
- DONE_TIMEOUT=4, `dp_done` on WAIT cycle 4 → accepted with no error. A stray `dp_done` in IDLE has no effect. `rst` asserted during WAIT of pass 2 → IDLE with `out_vec`=0.
- With `DENSE_SEQ_RELU_EN`: lane value −5 (0xFFFB) → stored as 0; +7 → stored as 7. Without the macro, 0xFFFB is stored unchanged.

Source files
------------

// File: rtl/dense_pass_scheduler.sv
// dense_pass_scheduler: runs a PAR-lane dense neuron bank NPASS times per
// input vector, gathers each pass's lane results into an output buffer and
// hands the full OUT_NEUR-wide vector downstream with valid/ready.
// Optional feature macro: DENSE_SEQ_RELU_EN (ReLU applied to captured lanes).
module dense_pass_scheduler #(
    parameter int DATA_W       = 16,
    parameter int OUT_NEUR     = 32,
    parameter int PAR          = 8,
    parameter int DONE_TIMEOUT = 1023,
    localparam int NPASS       = (OUT_NEUR + PAR - 1) / PAR,
    localparam int PASS_W      = (NPASS > 1) ? $clog2(NPASS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       dp_start,
    output logic [PASS_W-1:0]          dp_pass,
    input  logic                       dp_done,
    input  logic [PAR*DATA_W-1:0]      dp_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_NEUR*DATA_W-1:0] out_vec,
    output logic                       busy,
    output logic                       err
);

    localparam int CNT_W = $clog2(DONE_TIMEOUT + 1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NPASS - 1);
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(DONE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_OUT,
        S_ERR
    } state_t;

    state_t                       state_q, state_d;
    logic [PASS_W-1:0]            pass_q, pass_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [OUT_NEUR*DATA_W-1:0]   vec_q, vec_d;

    // Lane conditioning applied on capture: identity, or ReLU when enabled.
    function automatic logic [DATA_W-1:0] lane_fn(input logic [DATA_W-1:0] x);
`ifdef DENSE_SEQ_RELU_EN
        return x[DATA_W-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    // Next-state, pass sequencing, timeout counting and lane capture.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case leaves one unassigned, which would infer a latch.
        state_d = state_q;
        pass_d  = pass_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_START;
                    pass_d  = '0;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (dp_done) begin
                    // Slot j comes from lane j%PAR of pass j/PAR; lanes past
                    // OUT_NEUR on the last pass have no slot and are dropped.
                    for (int j = 0; j < OUT_NEUR; j++) begin
                        if (pass_q == PASS_W'(j / PAR)) begin
                            vec_d[j*DATA_W +: DATA_W] =
                                lane_fn(dp_out[(j % PAR)*DATA_W +: DATA_W]);
                        end
                    end
                    if (pass_q == LAST_PASS) begin
                        state_d = S_OUT;
                    end else begin
                        pass_d  = pass_q + PASS_W'(1);
                        state_d = S_START;
                    end
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    pass_d  = '0;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, pass index, timeout counter and output buffer registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its _d value from before this edge.
        if (rst) begin
            state_q <= S_IDLE;
            pass_q  <= '0;
            cnt_q   <= '0;
            // NOTE: the output buffer is cleared on reset because out_vec is
            // architecturally visible and must read zero after reset.
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign dp_start  = (state_q == S_START);
    assign dp_pass   = pass_q;
    assign out_valid = (state_q == S_OUT);
    assign out_vec   = vec_q;
    assign busy      = (state_q == S_START) || (state_q == S_WAIT) || (state_q == S_OUT);
    assign err       = (state_q == S_ERR);

endmodule

// File: tb/tb_dense_pass_scheduler.sv
// Randomized self-checking bench for dense_pass_scheduler. A behavioural
// model keeps the expected buffer as an array of slots and the expected
// handshake status per cycle; the neuron bank is emulated by the stimulus.
module tb_dense_pass_scheduler;

    localparam int DW    = 16;
    localparam int OUTN  = 32;
    localparam int PAR   = 12;
    localparam int TO    = 4;
    localparam int NPASS = (OUTN + PAR - 1) / PAR;
    localparam int PW    = (NPASS > 1) ? $clog2(NPASS) : 1;
    localparam int VW    = OUTN * DW;

    // Status word {in_ready, dp_start, out_valid, busy, err} per state.
    localparam logic [4:0] ST_IDLE  = 5'b10000;
    localparam logic [4:0] ST_START = 5'b01010;
    localparam logic [4:0] ST_WAIT  = 5'b00010;
    localparam logic [4:0] ST_OUT   = 5'b00110;
    localparam logic [4:0] ST_ERR   = 5'b00001;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              dp_start;
    logic [PW-1:0]     dp_pass;
    logic              dp_done;
    logic [PAR*DW-1:0] dp_out;
    logic              out_valid;
    logic              out_ready;
    logic [VW-1:0]     out_vec;
    logic              busy;
    logic              err;

    dense_pass_scheduler #(
        .DATA_W      (DW),
        .OUT_NEUR    (OUTN),
        .PAR         (PAR),
        .DONE_TIMEOUT(TO)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dp_start (dp_start),
        .dp_pass  (dp_pass),
        .dp_done  (dp_done),
        .dp_out   (dp_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_vec  (out_vec),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [DW-1:0] exp_slot [OUTN];

    task automatic check(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [VW-1:0] v;
        for (int j = 0; j < OUTN; j++) v[j*DW +: DW] = exp_slot[j];
        return v;
    endfunction

    function automatic logic [DW-1:0] model_lane(input logic [DW-1:0] x);
`ifdef DENSE_SEQ_RELU_EN
        return ($signed(x) < 0) ? '0 : x;
`else
        return x;
`endif
    endfunction

    function automatic logic [4:0] status();
        return {in_ready, dp_start, out_valid, busy, err};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic randomize_lanes();
        for (int i = 0; i < PAR; i++) dp_out[i*DW +: DW] = DW'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; dp_done = 1'b0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        for (int j = 0; j < OUTN; j++) exp_slot[j] = '0;
        check("rst_status", status(), ST_IDLE);
        check("rst_pass", dp_pass, 0);
        check("rst_vec", out_vec, exp_vec());
    endtask

    // Stray done pulses with random lanes while idle must change nothing.
    task automatic idle_noise(input int n);
        for (int c = 0; c < n; c++) begin
            dp_done = 1'b1;
            randomize_lanes();
            step();
            check("idle_status", status(), ST_IDLE);
            check("idle_vec", out_vec, exp_vec());
        end
        dp_done = 1'b0;
    endtask

    // One frame. kfix>0 fixes the done latency of every pass, else random.
    // abort_pass>=0 asserts rst on the first WAIT cycle of that pass.
    task automatic run_frame(input int kfix, input int stall, input int abort_pass, input bit neg_lane);
        int k;
        int cyc;
        int exp_cyc;
        check("accept_ready", status(), ST_IDLE);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        cyc      = 1;
        exp_cyc  = 1;
        for (int p = 0; p < NPASS; p++) begin
            check("start_status", status(), ST_START);
            check("start_pass", dp_pass, p);
            k = (kfix > 0) ? kfix : $urandom_range(1, TO);
            exp_cyc += k + 1;
            for (int w = 1; w <= k; w++) begin
                step();
                cyc++;
                if (p == abort_pass) begin
                    rst = 1'b1;
                    step();
                    rst = 1'b0;
                    for (int j = 0; j < OUTN; j++) exp_slot[j] = '0;
                    check("abort_status", status(), ST_IDLE);
                    check("abort_pass", dp_pass, 0);
                    check("abort_vec", out_vec, exp_vec());
                    return;
                end
                check("wait_status", status(), ST_WAIT);
                check("wait_pass", dp_pass, p);
                randomize_lanes();
                if (neg_lane && p == 0) begin
                    dp_out[0 +: DW]  = 16'hFFFB;
                    dp_out[DW +: DW] = 16'd7;
                end
                dp_done = (w == k);
                if (w == k) begin
                    for (int i = 0; i < PAR; i++)
                        if (p * PAR + i < OUTN) exp_slot[p*PAR + i] = model_lane(dp_out[i*DW +: DW]);
                end
            end
            step();
            cyc++;
            dp_done = 1'b0;
            randomize_lanes();
        end
        check("out_status", status(), ST_OUT);
        check("out_cycle", cyc, exp_cyc);
        check("out_vec", out_vec, exp_vec());
        if (neg_lane) begin
`ifdef DENSE_SEQ_RELU_EN
            check("relu_neg", out_vec[0 +: DW], 16'h0000);
`else
            check("raw_neg", out_vec[0 +: DW], 16'hFFFB);
`endif
            check("pos_lane", out_vec[DW +: DW], 16'd7);
        end
        for (int s = 0; s < stall; s++) begin
            dp_done = $urandom_range(0, 1) == 1;
            randomize_lanes();
            step();
            check("stall_status", status(), ST_OUT);
            check("stall_vec", out_vec, exp_vec());
        end
        dp_done   = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("post_status", status(), ST_IDLE);
        check("post_pass", dp_pass, 0);
        check("post_vec", out_vec, exp_vec());
    endtask

    task automatic run_timeout();
        check("to_ready", status(), ST_IDLE);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("to_start", status(), ST_START);
        for (int w = 1; w <= TO; w++) begin
            step();
            check("to_wait", status(), ST_WAIT);
        end
        step();
        check("to_err", status(), ST_ERR);
        for (int c = 0; c < 5; c++) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            dp_done   = 1'b1;
            step();
            check("err_sticky", status(), ST_ERR);
        end
        in_valid = 1'b0; out_ready = 1'b0; dp_done = 1'b0;
        do_reset();
    endtask

    initial begin
        dp_out = '0;
        do_reset();
        // Minimum latency, partial last pass, ReLU/raw sign handling.
        run_frame(1, 0, -1, 1'b1);
        // Latency on the final allowed WAIT cycle, long stall, back-to-back.
        run_frame(TO, 10, -1, 1'b0);
        run_frame(3, 0, -1, 1'b0);
        idle_noise(3);
        // Reset during the second pass discards the frame and clears the buffer.
        run_frame(2, 0, 1, 1'b0);
        run_frame(0, 2, -1, 1'b1);
        run_timeout();
        for (int f = 0; f < 12; f++) begin
            idle_noise($urandom_range(0, 2));
            run_frame(0, $urandom_range(0, 3), -1, 1'b0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
